// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin picker.
// The read-side scheduler can reuse the same picker and helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Index/counter width: ceil(log2(n)), never below one bit.
    function automatic int log2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the shared write port.
// slave is the arbiter's view, master is the requesters/FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]       last;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [WIDTH-1:0]         fifo_data;
    logic                     fifo_write;
    logic                     fifo_full;
    logic                     fifo_prg_full;

    modport slave (
        input  req, data_in, last, fifo_full, fifo_prg_full,
        output ack, grant, busy, fifo_data, fifo_write
    );

    modport master (
        output req, data_in, last, fifo_full, fifo_prg_full,
        input  ack, grant, busy, fifo_data, fifo_write
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit after ptr_i, wrapping.
// The requester at ptr_i itself has the lowest priority.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = log2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);
    logic [IDX_W-1:0] idx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port among NUM_REQ requesters.
// New bursts wait on prg_full; individual words wait on full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IDX_W = log2_min1(NUM_REQ);
    localparam int CNT_W = log2_min1(MAX_BURST);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     winner;
    logic                 win_vld;
    logic                 busy;
    logic [NUM_REQ-1:0]   ack;
    logic                 own_req, own_ack, own_last;
    logic [WIDTH-1:0]     slice [NUM_REQ];

    fifo_wr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .valid_o  (win_vld)
    );

    // While busy, ptr_q holds the owner index, so it doubles as the grant index.
    assign busy     = (state_q == ST_BURST);
    assign own_req  = bus.req[ptr_q];
    assign own_last = bus.last[ptr_q];
    assign own_ack  = |ack;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign slice[i] = bus.data_in[i*WIDTH +: WIDTH];
        assign ack[i]   = busy & (ptr_q == IDX_W'(i)) & bus.req[i] & ~bus.fifo_full;

        a_req_stable: assert property (@(posedge clk) disable iff (rst)
            (bus.req[i] && !ack[i]) |=> (!bus.req[i] || ($stable(slice[i]) && $stable(bus.last[i]))));
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !bus.fifo_prg_full) begin
                    state_d = ST_BURST;
                    grant_d = NUM_REQ'(1) << winner;
                    ptr_d   = winner;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                // Withdrawal ends the burst even if the FIFO is full this cycle.
                if (!own_req || (own_ack && (own_last || cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (own_ack) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ack        = ack;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy;
    assign bus.fifo_write = own_ack;
    assign bus.fifo_data  = busy ? slice[ptr_q] : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: a word-level requester/arbiter model predicts every cycle;
// a negedge monitor pops expectations and compares against the arbiter.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int W  = 8;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus();

    fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [W-1:0] d; bit l; } word_t;
    typedef struct { logic [NR-1:0] grant; bit busy; logic [NR-1:0] ack; } cyc_t;
    typedef struct { int idx; logic [W-1:0] d; } xfer_t;

    word_t pend [NR][$];
    bit    en [NR];
    int    drop_after [NR];
    cyc_t  exp_cyc [$];
    xfer_t exp_xfer [$];
    logic [NR-1:0] glog [$];
    logic [NR-1:0] prev_grant = '0;

    int checks = 0;
    int errors = 0;

    // Model: owner of the port (-1 idle), words taken in this burst, last winner.
    int m_owner = -1;
    int m_taken = 0;
    int m_last  = NR - 1;
    int full_cnt = 0, full_trig = -1, acks_seen = 0;
    bit rand_full = 0, rand_prg = 0, prg_force = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_burst(input int i, input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            word_t w;
            w.d = W'($urandom);
            w.l = with_last && (k == n - 1);
            pend[i].push_back(w);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            en[i] = 0;
            drop_after[i] = 0;
            pend[i].delete();
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < NR; i++) if (en[i] && pend[i].size() > 0) p = 1;
        return p;
    endfunction

    // One clock: drive inputs, predict outputs, advance model and requesters.
    task automatic step();
        logic [NR-1:0]   r, l, a;
        logic [NR*W-1:0] d;
        bit full, prg;
        cyc_t c;
        @(posedge clk); #1;
        full = rand_full ? ($urandom_range(4) == 0) : 1'b0;
        if (full_cnt > 0) begin
            full = 1;
            full_cnt--;
        end
        prg = prg_force | (rand_prg && $urandom_range(5) == 0);
        r = '0; l = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (pend[i].size() > 0) begin
                r[i] = en[i];
                d[i*W +: W] = pend[i][0].d;
                l[i] = pend[i][0].l;
            end
        end
        bus.req = r; bus.data_in = d; bus.last = l;
        bus.fifo_full = full; bus.fifo_prg_full = prg;

        a = '0; c.grant = '0; c.busy = 0;
        if (m_owner >= 0) begin
            c.grant[m_owner] = 1'b1;
            c.busy = 1;
            if (r[m_owner] && !full) a[m_owner] = 1'b1;
        end
        c.ack = a;
        exp_cyc.push_back(c);

        if (m_owner < 0) begin
            if (r != '0 && !prg) begin
                for (int k = 1; k <= NR; k++) begin
                    int j;
                    j = (m_last + k) % NR;
                    if (r[j]) begin
                        m_owner = j; m_last = j; m_taken = 0;
                        break;
                    end
                end
            end
        end else begin
            int o;
            o = m_owner;
            if (!r[o]) m_owner = -1;
            else if (a[o]) begin
                xfer_t x;
                x.idx = o; x.d = pend[o][0].d;
                exp_xfer.push_back(x);
                m_taken++;
                if (pend[o][0].l || m_taken == MB) m_owner = -1;
                void'(pend[o].pop_front());
                acks_seen++;
                if (acks_seen == full_trig) full_cnt = 5;
                if (drop_after[o] > 0) begin
                    drop_after[o]--;
                    if (drop_after[o] == 0) en[o] = 0;
                end
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        check("run_reached_idle", {31'd0, pending()}, 32'd0);
        step();
        step();
    endtask

    task automatic check_glog(input string nm, input logic [NR-1:0] e [$]);
        check({nm, "_count"}, glog.size(), e.size());
        for (int k = 0; k < e.size(); k++)
            check(nm, (k < glog.size()) ? glog[k] : 'x, e[k]);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            check("no_write_while_full", {31'd0, bus.fifo_write & bus.fifo_full}, 32'd0);
            if (exp_cyc.size() > 0) begin
                cyc_t c;
                c = exp_cyc.pop_front();
                check("grant", bus.grant, c.grant);
                check("busy", bus.busy, c.busy);
                check("ack", bus.ack, c.ack);
                check("fifo_write", bus.fifo_write, |c.ack);
            end
            if (bus.fifo_write) begin
                if (exp_xfer.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    xfer_t x;
                    x = exp_xfer.pop_front();
                    check("fifo_data", bus.fifo_data, x.d);
                    check("write_owner", bus.ack, NR'(1) << x.idx);
                end
            end
            if (bus.grant != prev_grant && bus.grant != '0) glog.push_back(bus.grant);
            prev_grant = bus.grant;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] e [$];
        rst = 0;
        bus.req = '0; bus.data_in = '0; bus.last = '0;
        bus.fifo_full = 0; bus.fifo_prg_full = 0;
        clear_reqs();
        #1 rst = 1;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_write", bus.fifo_write, 0);
        check("rst_ack", bus.ack, 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;

        // Two requesters, bursts of 3 with last: alternate 0,2,0,2.
        for (int b = 0; b < 2; b++) begin
            push_burst(0, 3, 1);
            push_burst(2, 3, 1);
        end
        en[0] = 1; en[2] = 1;
        glog.delete();
        run_until_idle(200);
        e = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        check_glog("alt_grant", e);
        clear_reqs();

        // Single requester, no last: MAX_BURST split and re-grant to itself.
        push_burst(1, 2 * MB, 0);
        en[1] = 1;
        glog.delete();
        run_until_idle(200);
        e = '{4'b0010, 4'b0010};
        check_glog("max_burst_grant", e);
        clear_reqs();

        // FIFO full for 5 cycles after the 2nd word.
        push_burst(0, 6, 1);
        en[0] = 1;
        acks_seen = 0; full_trig = 2;
        run_until_idle(200);
        full_trig = -1;
        clear_reqs();

        // prg_full gates new grants only.
        prg_force = 1;
        push_burst(3, 2, 1);
        en[3] = 1;
        glog.delete();
        repeat (4) step();
        @(negedge clk);
        check("prg_full_no_grant", bus.grant, 0);
        check("prg_full_not_busy", bus.busy, 0);
        prg_force = 0;
        run_until_idle(200);
        e = '{4'b1000};
        check_glog("prg_release_grant", e);
        clear_reqs();

        // Withdrawal: move pointer to 2, then 3 drops after one word and 0 follows.
        push_burst(2, 1, 1);
        en[2] = 1;
        run_until_idle(50);
        clear_reqs();
        push_burst(3, 4, 1);
        drop_after[3] = 1;
        push_burst(0, 2, 1);
        en[3] = 1; en[0] = 1;
        glog.delete();
        run_until_idle(200);
        e = '{4'b1000, 4'b0001};
        check_glog("withdraw_grant", e);
        clear_reqs();

        // Asynchronous reset mid-burst.
        for (int i = 0; i < NR; i++) begin
            push_burst(i, 4, 1);
            en[i] = 1;
        end
        repeat (3) step();
        @(negedge clk);
        #1 rst = 1;
        bus.req = '0;
        #1;
        check("midrst_grant", bus.grant, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ack", bus.ack, 0);
        check("midrst_write", bus.fifo_write, 0);
        check("midrst_data", bus.fifo_data, 0);
        clear_reqs();
        m_owner = -1; m_last = NR - 1; m_taken = 0;
        @(posedge clk);
        #3 rst = 0;
        for (int i = 0; i < NR; i++) begin
            push_burst(i, 2, 1);
            en[i] = 1;
        end
        glog.delete();
        run_until_idle(200);
        e = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        check_glog("post_rst_grant", e);
        clear_reqs();

        // Randomized traffic with random full, prg_full and withdrawals.
        rand_full = 1; rand_prg = 1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (pend[i].size() == 0 && $urandom_range(3) == 0) begin
                    int len;
                    len = $urandom_range(1, 10);
                    for (int k = 0; k < len; k++) begin
                        word_t w;
                        w.d = W'($urandom);
                        w.l = ($urandom_range(3) == 0) || (k == len - 1 && $urandom_range(1) == 0);
                        pend[i].push_back(w);
                    end
                end
                if ($urandom_range(15) == 0) en[i] = ~en[i];
            end
            step();
        end
        rand_full = 0; rand_prg = 0;
        for (int i = 0; i < NR; i++) en[i] = 1;
        run_until_idle(2000);

        @(negedge clk); #1;
        check("xfer_queue_drained", exp_xfer.size(), 0);
        check("cycle_queue_drained", exp_cyc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
